// File: rtl/manchester_rx.sv
// Manchester receiver: start symbol + 8 data bits (MSB first), first half inverted.
// Latency: data_valid rises 17*HALF + HALF/2 + 1 cycles after the synchronized start edge.
// No backpressure: a byte not taken during its data_valid pulse is lost.
module manchester_rx #(
    parameter int HALF = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       line_in,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       code_err,
    output logic       busy
);

    // Phase counter must hold 2*HALF-1.
    localparam int PW = $clog2(2 * HALF);

    // The phase counter is cleared at the start edge, so at the edge t0+n it
    // holds n-1 (mod 2*HALF). Each sample point is therefore a fixed phase value.
    localparam logic [PW-1:0] PH_START  = PW'(HALF - 1);
    localparam logic [PW-1:0] PH_FIRST  = PW'(HALF / 2 - 1);
    localparam logic [PW-1:0] PH_SECOND = PW'(HALF + HALF / 2 - 1);
    localparam logic [PW-1:0] PH_MAX    = PW'(2 * HALF - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        FIRST,
        SECOND,
        DONE
    } state_t;

    state_t          state;
    state_t          state_nx;

    logic            sync1;
    logic            s;
    logic            s_d;
    logic [PW-1:0]   ph;
    logic [2:0]      bit_cnt;
    logic [7:0]      shreg;
    logic            first_smp;
    logic            err_q;

    logic            ph_clr;
    logic            ld_first;
    logic            shift_en;
    logic            err_nx;
    logic            dv_nx;

    // Two-flop synchronizer plus one-cycle delayed copy for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            s     <= 1'b0;
            s_d   <= 1'b0;
        end else begin
            sync1 <= line_in;
            s     <= sync1;
            s_d   <= s;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic and datapath controls; samples are taken at fixed phases only,
    // so line edges while busy never restart a frame.
    always_comb begin
        state_nx = state;
        ph_clr   = 1'b0;
        ld_first = 1'b0;
        shift_en = 1'b0;
        err_nx   = 1'b0;
        dv_nx    = 1'b0;
        case (state)
            IDLE: begin
                if (s && !s_d) begin
                    state_nx = START;
                    ph_clr   = 1'b1;
                end
            end
            START: begin
                if (ph == PH_START) begin
                    state_nx = s ? FIRST : IDLE;
                end
            end
            FIRST: begin
                if (ph == PH_FIRST) begin
                    ld_first = 1'b1;
                    state_nx = SECOND;
                end
            end
            SECOND: begin
                if (ph == PH_SECOND) begin
                    if (s == first_smp) begin
                        err_nx   = 1'b1;
                        state_nx = IDLE;
                    end else begin
                        shift_en = 1'b1;
                        state_nx = (bit_cnt == 3'd7) ? DONE : FIRST;
                    end
                end
            end
            DONE: begin
                dv_nx    = 1'b1;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Phase counter: held at 0 while idle, wraps at every bit boundary.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ph <= '0;
        end else if (ph_clr || state == IDLE) begin
            ph <= '0;
        end else if (ph == PH_MAX) begin
            ph <= '0;
        end else begin
            ph <= ph + 1'b1;
        end
    end

    // Bit counter and shift register; second-half sample enters from the LSB side.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt   <= 3'd0;
            shreg     <= 8'h00;
            first_smp <= 1'b0;
        end else begin
            if (ph_clr) begin
                bit_cnt <= 3'd0;
                shreg   <= 8'h00;
            end else if (shift_en) begin
                bit_cnt <= bit_cnt + 3'd1;
                shreg   <= {shreg[6:0], s};
            end
            if (ld_first) begin
                first_smp <= s;
            end
        end
    end

    // Output registers: byte load and valid pulse in DONE; error pulse one cycle after the bad sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out   <= 8'h00;
            data_valid <= 1'b0;
            err_q      <= 1'b0;
            code_err   <= 1'b0;
        end else begin
            if (state == DONE) begin
                data_out <= shreg;
            end
            data_valid <= dv_nx;
            err_q      <= err_nx;
            code_err   <= err_q;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_manchester_rx.sv
// Directed bench for manchester_rx with HALF=8.
// Expected timing is computed from the drive point E: start edge t0 = E+3.
// Outputs are sampled 1 time unit after the rising edge.
module tb_manchester_rx;

    localparam int HALF = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       line_in;
    logic [7:0] data_out;
    logic       data_valid;
    logic       code_err;
    logic       busy;

    int cyc = 0;
    int errors = 0;
    int checks = 0;
    int dv_cnt = 0;
    int ce_cnt = 0;
    int both_cnt = 0;
    int dv_cyc = 0;
    int ce_cyc = 0;
    logic [7:0] dv_dat = 8'h00;
    int e0;

    manchester_rx #(.HALF(HALF)) dut (
        .clk        (clk),
        .rst        (rst),
        .line_in    (line_in),
        .data_out   (data_out),
        .data_valid (data_valid),
        .code_err   (code_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse recorder.
    always @(negedge clk) begin
        if (data_valid) begin
            dv_cnt = dv_cnt + 1;
            dv_cyc = cyc;
            dv_dat = data_out;
        end
        if (code_err) begin
            ce_cnt = ce_cnt + 1;
            ce_cyc = cyc;
        end
        if (data_valid && code_err) both_cnt = both_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_edges(input int n);
        if (n > 0) begin
            repeat (n) @(posedge clk);
            #1;
        end
    endtask

    // Called 1 unit after a rising edge; bad marks a bit with both halves high.
    task automatic send(input logic [7:0] b, input int nbits, input int bad, input int hold);
        line_in = 1'b1;
        wait_edges(2 * HALF);
        for (int i = 0; i < nbits; i++) begin
            line_in = (i == bad) ? 1'b1 : ~b[7-i];
            wait_edges(HALF);
            line_in = (i == bad) ? 1'b1 : b[7-i];
            wait_edges(HALF);
        end
        wait_edges(hold);
        line_in = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        line_in = 1'b0;
        wait_edges(3);
        check("reset_data_out", data_out, 8'h00);
        check("reset_data_valid", data_valid, 0);
        check("reset_code_err", code_err, 0);
        check("reset_busy", busy, 0);
        rst = 1'b0;
        wait_edges(5);

        // Clean 0xA5 with exact timing.
        e0 = cyc;
        fork
            send(8'hA5, 8, -1, 0);
            begin
                wait_edges(2);
                check("a5_busy_before_t0", busy, 0);
                wait_edges(2);
                check("a5_busy_t0p1", busy, 1);
                wait_edges(139);
                check("a5_busy_done", busy, 1);
                check("a5_dv_before", data_valid, 0);
                wait_edges(1);
                check("a5_dv_at_t0p141", data_valid, 1);
                check("a5_data_out", data_out, 8'hA5);
                check("a5_busy_after", busy, 0);
                wait_edges(1);
                check("a5_dv_one_cycle", data_valid, 0);
            end
        join
        wait_edges(8);
        check("a5_dv_count", dv_cnt, 1);
        check("a5_dv_cyc", dv_cyc, e0 + 144);
        check("a5_ce_count", ce_cnt, 0);

        // Back-to-back 0x00 then 0xFF with 4 idle cycles.
        send(8'h00, 8, -1, 0);
        wait_edges(4);
        check("b2b_first_count", dv_cnt, 2);
        check("b2b_first_data", dv_dat, 8'h00);
        send(8'hFF, 8, -1, 0);
        wait_edges(8);
        check("b2b_second_count", dv_cnt, 3);
        check("b2b_second_data", data_out, 8'hFF);

        // 0x3C with bit 4 both halves high; frame stops after the bad bit.
        e0 = cyc;
        fork
            send(8'h3C, 5, 4, 0);
            begin
                wait_edges(94);
                check("err_busy_before", busy, 1);
                wait_edges(1);
                check("err_busy_falls", busy, 0);
                check("err_ce_not_yet", code_err, 0);
                wait_edges(1);
                check("err_ce_pulse", code_err, 1);
                wait_edges(1);
                check("err_ce_one_cycle", code_err, 0);
            end
        join
        wait_edges(20);
        check("err_ce_count", ce_cnt, 1);
        check("err_ce_cyc", ce_cyc, e0 + 96);
        check("err_no_dv", dv_cnt, 3);
        check("err_data_kept", data_out, 8'hFF);

        // Glitch: 3 high cycles then low.
        e0 = cyc;
        line_in = 1'b1;
        wait_edges(3);
        line_in = 1'b0;
        wait_edges(2);
        check("glitch_busy", busy, 1);
        wait_edges(7);
        check("glitch_idle", busy, 0);
        wait_edges(10);
        check("glitch_no_dv", dv_cnt, 3);
        check("glitch_no_ce", ce_cnt, 1);
        send(8'h81, 8, -1, 0);
        wait_edges(8);
        check("glitch_next_count", dv_cnt, 4);
        check("glitch_next_data", data_out, 8'h81);

        // Reset at bit 3 of 0x5A.
        send(8'h5A, 3, -1, 0);
        check("rst_busy_midframe", busy, 1);
        rst = 1'b1;
        wait_edges(2);
        check("rst_data_out", data_out, 8'h00);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        wait_edges(30);
        check("rst_busy_after", busy, 0);
        check("rst_no_dv", dv_cnt, 4);
        check("rst_no_ce", ce_cnt, 1);
        e0 = cyc;
        send(8'hC3, 8, -1, 0);
        wait_edges(8);
        check("rst_next_count", dv_cnt, 5);
        check("rst_next_data", data_out, 8'hC3);
        check("rst_next_cyc", dv_cyc, e0 + 144);

        // 0x01 with line held high 10 extra cycles.
        e0 = cyc;
        send(8'h01, 8, -1, 10);
        check("hold_busy_high_line", busy, 0);
        wait_edges(40);
        check("hold_dv_count", dv_cnt, 6);
        check("hold_data", data_out, 8'h01);
        check("hold_dv_cyc", dv_cyc, e0 + 144);
        check("hold_no_restart", busy, 0);
        check("hold_no_ce", ce_cnt, 1);
        check("never_both", both_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
